// File: rtl/serial_word_transmitter_if.sv
// Load/Ready handshake plus serial-line status for the serial word transmitter.
interface serial_word_transmitter_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] Data;
  logic             Load;
  logic             Ready;
  logic             SerialOut;
  logic             Busy;
  logic             Done;

  // Producer side: offers a word and watches the line.
  modport master (
    output Data, Load,
    input  Ready, SerialOut, Busy, Done
  );

  // Transmitter side.
  modport slave (
    input  Data, Load,
    output Ready, SerialOut, Busy, Done
  );
endinterface

// File: rtl/serial_word_transmitter.sv
// Parallel-in, serial-out framed transmitter: start bit (0), WIDTH data bits,
// stop bit (1), each bit held for BIT_CYCLES clocks. All outputs registered.
module serial_word_transmitter #(
  parameter int WIDTH      = 4,
  parameter int BIT_CYCLES = 1,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic                      Clock,
  input  logic                      Reset,
  serial_word_transmitter_if.slave  bus
);

  localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH + 1) : 1;
  localparam logic [CW-1:0] CYC_LAST = CW'(BIT_CYCLES - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [CW-1:0]    cyc_cnt_q, cyc_cnt_d;
  logic             serial_q, serial_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             bit_end;
  logic             head_bit;

  assign bit_end = (cyc_cnt_q == CYC_LAST);

  // Next-state, counter and registered-output computation.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned and infers a latch.
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    cyc_cnt_d = cyc_cnt_q;
    done_d    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.Load) begin
          shift_d   = bus.Data;
          cyc_cnt_d = '0;
          state_d   = ST_START;
        end
      end
      ST_START: begin
        if (bit_end) begin
          cyc_cnt_d = '0;
          bit_cnt_d = '0;
          state_d   = ST_DATA;
        end else begin
          cyc_cnt_d = cyc_cnt_q + CW'(1);
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          cyc_cnt_d = '0;
          shift_d   = MSB_FIRST ? (shift_q << 1) : (shift_q >> 1);
          if (bit_cnt_q == BIT_LAST) begin
            bit_cnt_d = '0;
            state_d   = ST_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + BW'(1);
          end
        end else begin
          cyc_cnt_d = cyc_cnt_q + CW'(1);
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          cyc_cnt_d = '0;
          done_d    = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          cyc_cnt_d = cyc_cnt_q + CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are derived from the next state so they are valid the cycle after the edge.
    head_bit = MSB_FIRST ? shift_d[WIDTH-1] : shift_d[0];
    unique case (state_d)
      ST_START: serial_d = 1'b0;
      ST_DATA:  serial_d = head_bit;
      default:  serial_d = 1'b1;
    endcase
    ready_d = (state_d == ST_IDLE);
    busy_d  = (state_d != ST_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge Clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (Reset) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      cyc_cnt_q <= '0;
      serial_q  <= 1'b1;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      cyc_cnt_q <= cyc_cnt_d;
      serial_q  <= serial_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.SerialOut = serial_q;
  assign bus.Ready     = ready_q;
  assign bus.Busy      = busy_q;
  assign bus.Done      = done_q;

endmodule

// File: tb/tb_serial_word_transmitter.sv
// Directed bench for serial_word_transmitter across three configurations:
// MSB-first, LSB-first and three clocks per bit.
module tb_serial_word_transmitter;

  logic Clock;
  logic Reset;
  int   checks;
  int   errors;

  serial_word_transmitter_if #(.WIDTH(4)) if_m ();
  serial_word_transmitter_if #(.WIDTH(4)) if_l ();
  serial_word_transmitter_if #(.WIDTH(4)) if_s ();

  serial_word_transmitter #(.WIDTH(4), .BIT_CYCLES(1), .MSB_FIRST(1'b1)) u_msb (
    .Clock(Clock), .Reset(Reset), .bus(if_m.slave));
  serial_word_transmitter #(.WIDTH(4), .BIT_CYCLES(1), .MSB_FIRST(1'b0)) u_lsb (
    .Clock(Clock), .Reset(Reset), .bus(if_l.slave));
  serial_word_transmitter #(.WIDTH(4), .BIT_CYCLES(3), .MSB_FIRST(1'b1)) u_slow (
    .Clock(Clock), .Reset(Reset), .bus(if_s.slave));

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  // Observed vectors are {SerialOut, Busy, Ready, Done}.

  // Reset held with Load=1: everything stays idle; a frame starts once Reset drops.
  task automatic test_reset();
    logic [3:0] obs;
    @(negedge Clock);
    Reset = 1'b1;
    if_m.Load = 1'b1; if_m.Data = 4'hA;
    if_l.Load = 1'b1; if_l.Data = 4'hA;
    if_s.Load = 1'b1; if_s.Data = 4'hA;
    for (int c = 0; c < 4; c++) begin
      @(negedge Clock);
      obs = {if_m.SerialOut, if_m.Busy, if_m.Ready, if_m.Done};
      checks++;
      if (obs !== 4'b1010) begin
        errors++;
        $display("FAIL reset_msb cycle %0d: got %b expected 1010", c, obs);
      end
      obs = {if_l.SerialOut, if_l.Busy, if_l.Ready, if_l.Done};
      checks++;
      if (obs !== 4'b1010) begin
        errors++;
        $display("FAIL reset_lsb cycle %0d: got %b expected 1010", c, obs);
      end
      obs = {if_s.SerialOut, if_s.Busy, if_s.Ready, if_s.Done};
      checks++;
      if (obs !== 4'b1010) begin
        errors++;
        $display("FAIL reset_slow cycle %0d: got %b expected 1010", c, obs);
      end
    end
    Reset = 1'b0;
    @(negedge Clock);
    // Load was still high at the release edge, so the start bit appears.
    obs = {if_m.SerialOut, if_m.Busy, if_m.Ready, if_m.Done};
    checks++;
    if (obs !== 4'b0100) begin
      errors++;
      $display("FAIL reset_release_start: got %b expected 0100", obs);
    end
    if_m.Load = 1'b0; if_l.Load = 1'b0; if_s.Load = 1'b0;
    // Let any frames drain, then re-reset to a clean idle.
    Reset = 1'b1;
    @(negedge Clock);
    Reset = 1'b0;
    repeat (2) @(negedge Clock);
  endtask

  // MSB-first, one clock per bit, Data=1011.
  task automatic test_msb_frame();
    logic [3:0] obs, exp;
    bit ser [8] = '{0, 1, 0, 1, 1, 1, 1, 1};
    if_m.Data = 4'b1011; if_m.Load = 1'b1;
    @(negedge Clock);
    for (int c = 0; c < 8; c++) begin
      if (c == 0) begin
        if_m.Load = 1'b0;
        if_m.Data = 4'b0000;
      end
      exp = {ser[c], (c < 6), (c >= 6), (c == 6)};
      obs = {if_m.SerialOut, if_m.Busy, if_m.Ready, if_m.Done};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL msb_frame cycle %0d: got %b expected %b", c, obs, exp);
      end
      @(negedge Clock);
    end
  endtask

  // LSB-first, one clock per bit, Data=1011.
  task automatic test_lsb_frame();
    logic [3:0] obs, exp;
    bit ser [8] = '{0, 1, 1, 0, 1, 1, 1, 1};
    if_l.Data = 4'b1011; if_l.Load = 1'b1;
    @(negedge Clock);
    for (int c = 0; c < 8; c++) begin
      if (c == 0) if_l.Load = 1'b0;
      exp = {ser[c], (c < 6), (c >= 6), (c == 6)};
      obs = {if_l.SerialOut, if_l.Busy, if_l.Ready, if_l.Done};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL lsb_frame cycle %0d: got %b expected %b", c, obs, exp);
      end
      @(negedge Clock);
    end
  endtask

  // Three clocks per bit, Data=0110, MSB-first.
  task automatic test_slow_frame();
    logic [3:0] obs, exp;
    bit lvl [7] = '{0, 0, 1, 1, 0, 1, 1};
    if_s.Data = 4'b0110; if_s.Load = 1'b1;
    @(negedge Clock);
    for (int c = 0; c < 21; c++) begin
      if (c == 0) begin
        if_s.Load = 1'b0;
        if_s.Data = 4'b1001;
      end
      exp = {lvl[c / 3], (c < 18), (c >= 18), (c == 18)};
      obs = {if_s.SerialOut, if_s.Busy, if_s.Ready, if_s.Done};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL slow_frame cycle %0d: got %b expected %b", c, obs, exp);
      end
      @(negedge Clock);
    end
  endtask

  // Load held high: second frame accepted in the Done cycle; mid-frame Data changes ignored.
  task automatic test_back_to_back();
    logic [3:0] obs, exp;
    bit ser [15] = '{0, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 1, 1, 1};
    bit bsy;
    if_m.Data = 4'hF; if_m.Load = 1'b1;
    @(negedge Clock);
    for (int c = 0; c < 15; c++) begin
      if (c == 0) if_m.Data = 4'h0;
      if (c == 7) if_m.Load = 1'b0;
      bsy = (c < 6) || (c >= 7 && c < 13);
      exp = {ser[c], bsy, !bsy, (c == 6 || c == 13)};
      obs = {if_m.SerialOut, if_m.Busy, if_m.Ready, if_m.Done};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL back_to_back cycle %0d: got %b expected %b", c, obs, exp);
      end
      @(negedge Clock);
    end
  endtask

  // Reset during cycle 3 aborts the frame with no Done; a later frame is clean.
  task automatic test_reset_mid_frame();
    logic [3:0] obs, exp;
    bit ser [8] = '{0, 1, 0, 1, 1, 1, 1, 1};
    if_m.Data = 4'b1011; if_m.Load = 1'b1;
    @(negedge Clock);
    if_m.Load = 1'b0;
    repeat (3) @(negedge Clock);
    Reset = 1'b1;
    @(negedge Clock);
    Reset = 1'b0;
    for (int c = 4; c < 10; c++) begin
      obs = {if_m.SerialOut, if_m.Busy, if_m.Ready, if_m.Done};
      checks++;
      if (obs !== 4'b1010) begin
        errors++;
        $display("FAIL reset_abort cycle %0d: got %b expected 1010", c, obs);
      end
      @(negedge Clock);
    end
    if_m.Data = 4'b1011; if_m.Load = 1'b1;
    @(negedge Clock);
    for (int c = 0; c < 8; c++) begin
      if (c == 0) if_m.Load = 1'b0;
      exp = {ser[c], (c < 6), (c >= 6), (c == 6)};
      obs = {if_m.SerialOut, if_m.Busy, if_m.Ready, if_m.Done};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL reset_recover cycle %0d: got %b expected %b", c, obs, exp);
      end
      @(negedge Clock);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    Reset  = 1'b1;
    if_m.Load = 1'b0; if_m.Data = '0;
    if_l.Load = 1'b0; if_l.Data = '0;
    if_s.Load = 1'b0; if_s.Data = '0;
    repeat (2) @(negedge Clock);
    Reset = 1'b0;
    test_reset();
    test_msb_frame();
    test_lsb_frame();
    test_slow_frame();
    test_back_to_back();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_word_transmitter.md
Name: serial_word_transmitter

Overview:
- Parallel-in, serial-out framed transmitter: the outbound end of the team's parallel-load register path.
- Accepts a WIDTH-bit word on a Load/Ready handshake and shifts it out on one line: start bit (0), WIDTH data bits, stop bit (1).
- Each bit is held for BIT_CYCLES clocks.
- Feeds a single-wire serial link or a downstream serial-in register/receiver.

Parameters:
WIDTH, 4, data word width in bits (>=1)
BIT_CYCLES, 1, clocks per serial bit (>=1)
MSB_FIRST, 1, 1 = shift Data[WIDTH-1] first, 0 = shift Data[0] first

Ports:
Clock  input  1  rising-edge system clock
Reset  input  1  synchronous, active-high reset
Data  input  WIDTH  word to transmit, sampled only on an accepted Load
Load  input  1  request to start a frame
Ready  output  1  high when a Load will be accepted this cycle
SerialOut  output  1  serial line, idles high
Busy  output  1  high while a frame is in progress (START/DATA/STOP)
Done  output  1  one-cycle pulse when a frame completes

Behaviour:
- Interface (already decided): one clock, Clock; reset is synchronous and active-high, Reset.
- All outputs are registered. State and counters change only on the rising edge of Clock.
- Reset: sampled at the edge, overrides everything. After that edge:
  - State is IDLE, SerialOut=1, Ready=1, Busy=0, Done=0.
  - Shift register, bit counter and cycle counter are all 0.
- States: IDLE, START, DATA, STOP.
- IDLE:
  - Ready=1, Busy=0, SerialOut=1.
  - Load=1 at edge E0: capture Data into the shift register and go to START. After E0: Ready=0, Busy=1, SerialOut=0.
- START: SerialOut=0 for BIT_CYCLES cycles, then go to DATA with bit counter=0.
- DATA:
  - SerialOut is the current head bit: MSB when MSB_FIRST=1, LSB otherwise.
  - Each bit is held for BIT_CYCLES cycles, then the register shifts and the bit counter increments.
  - After WIDTH bits, go to STOP.
- STOP: SerialOut=1 for BIT_CYCLES cycles, then return to IDLE. In that first IDLE cycle: Done=1, Ready=1, Busy=0.
- Done: high for exactly one cycle, cleared at the next edge.
- Timing relative to E0:
  - Start bit occupies cycles 0..BIT_CYCLES-1.
  - Data bit k occupies cycles (k+1)*BIT_CYCLES .. (k+2)*BIT_CYCLES-1.
  - Stop bit follows the last data bit.
  - Done is high in cycle (WIDTH+2)*BIT_CYCLES.
- Back-to-back: Load=1 in the Done cycle is accepted. Consecutive frames are therefore separated by exactly one idle-high cycle.
- Load while Busy=1: ignored, with no effect on the frame or the shift register. Changes on Data during a frame have no effect.
- Reset mid-frame: the frame aborts at the reset edge. SerialOut=1 from the next cycle; no Done pulse.
- Counter widths:
  - Cycle counter: clog2(BIT_CYCLES), minimum 1 bit; counts 0..BIT_CYCLES-1.
  - Bit counter: clog2(WIDTH+1) bits; counts 0..WIDTH-1.
  - No wrap occurs outside these ranges.
- Zero-fill shifts in behind the data. The shift register content after a frame is don't-care.

Test Plan:
1. WIDTH=4, BIT_CYCLES=1, MSB_FIRST=1, Data=4'b1011, Load pulsed at E0 -> SerialOut on cycles 0..5 = 0,1,0,1,1,1; Done=1 and Ready=1 on cycle 6 only; Busy=1 on cycles 0..5.
2. Same as scenario 1 with MSB_FIRST=0 -> SerialOut = 0,1,1,0,1,1; Done on cycle 6.
3. BIT_CYCLES=3, Data=4'b0110, MSB_FIRST=1 -> each level held 3 cycles: 000 000 111 111 000 111 (start, 0, 1, 1, 0, stop); Done on cycle 18.
4. Load=1 held continuously, Data=4'hF then 4'h0 after E0 (BIT_CYCLES=1, MSB_FIRST=1):
   - First frame: 0,1,1,1,1,1 (Data change ignored mid-frame).
   - Cycle 6: idle 1 with Done=1, and the Load in this cycle is accepted.
   - Second frame on cycles 7..12: 0,0,0,0,0,1.
5. Reset asserted at cycle 3 of frame 4'b1011 -> from cycle 4: SerialOut=1, Ready=1, Busy=0; Done never pulses; a new Load afterwards produces a clean full frame.
6. Reset held high with Load=1 and Data=4'hA -> SerialOut=1, Ready=1, Busy=0, Done=0 every cycle; no frame starts until Reset drops.
